filter_stream_buffer: RTL
=========================

FILTER_STREAM_BUFFER -- requirements
Module: filter_stream_buffer

Interface
REQ-001 Parameter IN_W, default 32, width of one written filter word.
REQ-002 Parameter ELEM_W, default 8, width of one streamed filter element; IN_W SHALL be an integer multiple of ELEM_W.
REQ-003 Parameter FILT_WORDS, default 4, words per filter; element count E = FILT_WORDS*IN_W/ELEM_W.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  write one word into the current fill bank.
REQ-007 wr_data  in  IN_W  filter word.
REQ-008 wr_full  out  1  both banks hold complete filters; writes are refused.
REQ-009 wr_ovf  out  1  sticky: a write was attempted while wr_full.
REQ-010 bank_ready  out  1  at least one complete filter is held.
REQ-011 rd_start  in  1  begin streaming the oldest complete bank.
REQ-012 rd_en  in  1  consume current element.
REQ-013 rd_release  in  1  free the held bank (replay mode only).
REQ-014 rd_data  out  ELEM_W  current element.
REQ-015 rd_valid  out  1  rd_data is valid.
REQ-016 rd_last  out  1  current element is element E-1.

Function
REQ-017 Two banks (ping-pong); the writer fills one bank while the reader streams the other.
REQ-018 Accepted write (wr_en && !wr_full) stores the word at the next word slot of the fill bank; on word FILT_WORDS-1 the bank is marked full and the fill pointer toggles.
REQ-019 Element order: first-written word first, MSB element of each word first.
REQ-020 Reader FSM states IDLE, STREAM, HOLD.
REQ-021 IDLE -> STREAM on rd_start && bank_ready; index cleared; rd_start ignored when !bank_ready.
REQ-022 rd_valid = (state == STREAM), asserted from the cycle after rd_start is accepted; rd_data/rd_last are a combinational function of the read bank and index (first-word-fall-through).
REQ-023 In STREAM, rd_en advances the index by one; rd_en on rd_last ends the pass; rd_en outside STREAM is ignored; rd_start in STREAM is ignored.
REQ-024 Bank count SHALL change by +1 on write completion and -1 on bank free; both in the same cycle leave the count unchanged and both take effect.
REQ-025 Reader always serves banks in completion order; the read pointer toggles when a bank is freed.
REQ-026 wr_ovf is set on wr_en && wr_full and cleared only by rst; the refused word is discarded.

Reset
REQ-027 rst SHALL force state IDLE, index 0, write slot 0, both pointers to bank 0, both banks empty, wr_full/wr_ovf/bank_ready/rd_valid/rd_last = 0, rd_data = 0.
REQ-028 rst mid-stream or mid-fill aborts the operation; bank contents need not be cleared.

Configuration
REQ-029 Macro FILTER_STREAM_BUFFER_REPLAY_EN defined: after the last element the FSM enters HOLD; rd_start in HOLD restarts STREAM on the same bank from index 0; rd_release in HOLD frees the bank and returns to IDLE; rd_release wins over a simultaneous rd_start.
REQ-030 Macro undefined: after the last element the bank is freed and the FSM returns to IDLE; HOLD is unreachable; rd_release is ignored.

Structure
REQ-031 Package fsb_pkg holds the reader state enum and the element-count function of (IN_W, ELEM_W, FILT_WORDS).
REQ-032 Sub-module fsb_bank (one filter bank: word-slot write, element-index read mux) is instantiated twice.

Verification
REQ-033 Defaults; write 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10; rd_start; rd_en held -> rd_data 0x01..0x10 over 16 cycles, rd_last only on 0x10, bank_ready low after the last element.
REQ-034 Write two full filters without reading -> wr_full=1; a ninth wr_en -> wr_ovf=1, word dropped, first stream still begins 0x01.
REQ-035 Stream bank A while writing bank B; B completion coincides with A's last rd_en -> bank_ready stays 1 and the next rd_start streams B.
REQ-036 REPLAY_EN: stream A fully, rd_start -> A replays from 0x01; rd_release with rd_start same cycle -> IDLE, bank freed.
REQ-037 rst asserted at element 5 of a stream and at word 2 of a fill -> all outputs zero next cycle; a fresh 4-word write then streams correctly.

Source files
------------

// File: rtl/filter_stream_buffer_pkg.sv
// Shared types and sizing helpers for the ping-pong filter stream buffer.
package fsb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2
  } rd_state_e;

  function automatic int elem_count(int in_w, int elem_w, int filt_words);
    return (filt_words * in_w) / elem_w;
  endfunction

endpackage

// File: rtl/filter_stream_buffer_if.sv
// Write/read handshake bundle; master drives writes and reader controls, slave is the buffer.
interface filter_stream_buffer_if #(
  parameter int IN_W   = 32,
  parameter int ELEM_W = 8
);
  logic              wr_en;
  logic [IN_W-1:0]   wr_data;
  logic              wr_full;
  logic              wr_ovf;
  logic              bank_ready;
  logic              rd_start;
  logic              rd_en;
  logic              rd_release;
  logic [ELEM_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;

  modport master (
    output wr_en, wr_data, rd_start, rd_en, rd_release,
    input  wr_full, wr_ovf, bank_ready, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  wr_en, wr_data, rd_start, rd_en, rd_release,
    output wr_full, wr_ovf, bank_ready, rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/fsb_bank.sv
// One filter bank: word-slot write port and element-index read mux (first word, MSB element first).
module fsb_bank
  import fsb_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int ELEM_W     = 8,
  parameter int FILT_WORDS = 4,
  parameter int E          = elem_count(IN_W, ELEM_W, FILT_WORDS),
  parameter int SLOT_W     = (FILT_WORDS > 1) ? $clog2(FILT_WORDS) : 1,
  parameter int IDX_W      = (E > 1) ? $clog2(E) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic [IN_W-1:0]   wdata_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [ELEM_W-1:0] rdata_o
);

  // Word 0 is stored in the top slot so the packed vector reads MSB-first in write order.
  logic [FILT_WORDS-1:0][IN_W-1:0] mem_q;
  logic [E-1:0][ELEM_W-1:0]        elems;
  logic [IDX_W-1:0]                rev_idx;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[SLOT_W'(FILT_WORDS-1) - slot_i] <= wdata_i;
  end

  assign elems   = mem_q;
  assign rev_idx = IDX_W'(E-1) - idx_i;
  assign rdata_o = elems[rev_idx];

endmodule

// File: rtl/filter_stream_buffer.sv
// Two-bank ping-pong filter buffer: word writes in, element stream out.
// Optional replay/hold of a streamed bank: define FILTER_STREAM_BUFFER_REPLAY_EN.
module filter_stream_buffer
  import fsb_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int ELEM_W     = 8,
  parameter int FILT_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  filter_stream_buffer_if.slave  bus
);

  localparam int E      = elem_count(IN_W, ELEM_W, FILT_WORDS);
  localparam int IDX_W  = (E > 1) ? $clog2(E) : 1;
  localparam int SLOT_W = (FILT_WORDS > 1) ? $clog2(FILT_WORDS) : 1;

  rd_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              full, wr_acc, wr_done, rd_free, at_last, valid;
  logic [1:0]                    bank_we;
  logic [1:0][ELEM_W-1:0]        bank_rdata;

  assign full    = (cnt_q == 2'd2);
  assign wr_acc  = bus.wr_en && !full;
  assign wr_done = wr_acc && (slot_q == SLOT_W'(FILT_WORDS-1));
  assign at_last = (idx_q == IDX_W'(E-1));
  assign valid   = (state_q == ST_STREAM);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_acc && (wr_ptr_q == 1'(b));
    fsb_bank #(
      .IN_W(IN_W), .ELEM_W(ELEM_W), .FILT_WORDS(FILT_WORDS)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .slot_i  (slot_q),
      .wdata_i (bus.wr_data),
      .idx_i   (idx_q),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_free = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rd_start && (cnt_q != 2'd0)) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
      end
      ST_STREAM: begin
        if (bus.rd_en) begin
          if (at_last) begin
            idx_d = '0;
`ifdef FILTER_STREAM_BUFFER_REPLAY_EN
            state_d = ST_HOLD;
`else
            state_d = ST_IDLE;
            rd_free = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
`ifdef FILTER_STREAM_BUFFER_REPLAY_EN
        // Release takes priority so a bank can't be replayed and freed at once.
        if (bus.rd_release) begin
          state_d = ST_IDLE;
          rd_free = 1'b1;
        end else if (bus.rd_start) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef FILTER_STREAM_BUFFER_REPLAY_EN
  logic unused_release;
  assign unused_release = bus.rd_release;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q ^ wr_done;
    rd_ptr_d = rd_ptr_q ^ rd_free;
    ovf_d    = ovf_q | (bus.wr_en && full);
    if (wr_acc) slot_d = wr_done ? '0 : slot_q + 1'b1;
    unique case ({wr_done, rd_free})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      slot_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs are gated by STREAM so reset/idle show zero regardless of stale bank contents.
  assign bus.wr_full    = full;
  assign bus.wr_ovf     = ovf_q;
  assign bus.bank_ready = (cnt_q != 2'd0);
  assign bus.rd_valid   = valid;
  assign bus.rd_last    = valid && at_last;
  assign bus.rd_data    = valid ? bank_rdata[rd_ptr_q] : '0;

endmodule
